// File: rtl/lcd_bus_sched.sv
// lcd_bus_sched: HD44780 8-bit bus scheduler -- power-on init, then round-robin between two byte requesters.
// Define LCD_LOCK_EN to add REQn_LOCK inputs that let a requester own the bus for an unbroken burst.
module lcd_bus_sched #(
    parameter int unsigned T_POWERON = 1000000,
    parameter int unsigned T_SETUP   = 4,
    parameter int unsigned T_EN      = 25,
    parameter int unsigned T_HOLD    = 4,
    parameter int unsigned T_EXEC    = 2500,
    parameter int unsigned T_CLR     = 100000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       REQ0_VALID,
    input  logic       REQ0_RS,
    input  logic [7:0] REQ0_DATA,
    output logic       REQ0_ACK,
    input  logic       REQ1_VALID,
    input  logic       REQ1_RS,
    input  logic [7:0] REQ1_DATA,
    output logic       REQ1_ACK,
`ifdef LCD_LOCK_EN
    input  logic       REQ0_LOCK,
    input  logic       REQ1_LOCK,
`endif
    output logic       RS,
    output logic       EN_OUT,
    output logic [7:0] data,
    output logic       BUSY,
    output logic       INIT_DONE
);
    typedef enum logic [2:0] {PWR_WAIT, INIT_LOAD, SETUP, EN_HIGH, HOLD, EXEC_WAIT, IDLE} state_t;

    localparam logic [23:0] L_PWR   = 24'(T_POWERON - 1);
    localparam logic [23:0] L_SETUP = 24'(T_SETUP - 1);
    localparam logic [23:0] L_EN    = 24'(T_EN - 1);
    localparam logic [23:0] L_HOLD  = 24'(T_HOLD - 1);
    localparam logic [23:0] L_EXEC  = 24'(T_EXEC - 1);
    localparam logic [23:0] L_CLR   = 24'(T_CLR - 1);

    state_t      r_state, w_next;
    logic [23:0] r_cnt, w_load;
    logic [2:0]  r_idx;
    logic [7:0]  r_data, w_rom;
    logic        r_rs, r_init_done, r_last, r_own, r_owner, r_ack0, r_ack1;
    logic        w_lk0, w_lk1, w_own_act, w_g0, w_g1, w_clr;

`ifdef LCD_LOCK_EN
    assign w_lk0 = REQ0_LOCK;
    assign w_lk1 = REQ1_LOCK;
`else
    assign w_lk0 = 1'b0;
    assign w_lk1 = 1'b0;
`endif

    // The owner keeps the bus only while it holds both VALID and LOCK in IDLE.
    assign w_own_act = r_own && (r_owner ? (REQ1_VALID && w_lk1) : (REQ0_VALID && w_lk0));
    assign w_g0      = r_state == IDLE && REQ0_VALID && (w_own_act ? !r_owner : (!REQ1_VALID || r_last));
    assign w_g1      = r_state == IDLE && REQ1_VALID && !w_g0;
    assign w_clr     = !r_rs && r_data[7:2] == 6'd0;
    assign w_rom     = r_idx == 3'd4 ? 8'h01 : r_idx == 3'd3 ? 8'h06 : r_idx == 3'd2 ? 8'h0C : 8'h38;
    assign w_load    = w_next == SETUP ? L_SETUP : w_next == EN_HIGH ? L_EN :
                       w_next == HOLD ? L_HOLD : w_clr ? L_CLR : L_EXEC;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= PWR_WAIT;
            r_cnt   <= L_PWR;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? w_load : r_cnt - 24'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            PWR_WAIT:  if (r_cnt == 24'd0) w_next = INIT_LOAD;
            INIT_LOAD: w_next = SETUP;
            SETUP:     if (r_cnt == 24'd0) w_next = EN_HIGH;
            EN_HIGH:   if (r_cnt == 24'd0) w_next = HOLD;
            HOLD:      if (r_cnt == 24'd0) w_next = EXEC_WAIT;
            EXEC_WAIT: if (r_cnt == 24'd0) w_next = (r_init_done || r_idx == 3'd5) ? IDLE : INIT_LOAD;
            IDLE:      if (w_g0 || w_g1) w_next = SETUP;
            default:   w_next = PWR_WAIT;
        endcase
    end

    always_comb begin
        EN_OUT = r_state == EN_HIGH;
        BUSY   = r_state != IDLE;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rs        <= 1'b0;
            r_data      <= 8'h00;
            r_idx       <= 3'd0;
            r_init_done <= 1'b0;
            r_last      <= 1'b1;
            r_own       <= 1'b0;
            r_owner     <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
        end else begin
            r_ack0 <= w_g0;
            r_ack1 <= w_g1;
            if (r_state == INIT_LOAD) begin
                r_rs   <= 1'b0;
                r_data <= w_rom;
                r_idx  <= r_idx + 3'd1;
            end else if (w_g0 || w_g1) begin
                r_rs   <= w_g1 ? REQ1_RS : REQ0_RS;
                r_data <= w_g1 ? REQ1_DATA : REQ0_DATA;
            end
            if (r_state == EXEC_WAIT && w_next == IDLE)
                r_init_done <= 1'b1;
            if (r_state == IDLE) begin
                r_own   <= w_g0 ? w_lk0 : (w_g1 && w_lk1);
                r_owner <= w_g1;
                if ((w_g0 || w_g1) && !w_own_act)
                    r_last <= w_g1;
            end
        end
    end

    assign RS        = r_rs;
    assign data      = r_data;
    assign REQ0_ACK  = r_ack0;
    assign REQ1_ACK  = r_ack1;
    assign INIT_DONE = r_init_done;
endmodule
